// File: rtl/order_ingress_arbiter.sv
// Two-stream ingress arbiter: buffers CPU requests and exchange cancellations in
// separate FIFOs and serialises them into isolated one-cycle go pulses.
module order_ingress_arbiter #(
    parameter int DEPTH      = 4,
    parameter int GAP        = 2,
    parameter int EXCH_BURST = 3
) (
    input  logic                       clk,
    input  logic                       HRESETn,
    input  logic                       cpu_in_valid,
    output logic                       cpu_in_ready,
    input  logic [4:0]                 cpu_in_client_id,
    input  logic [31:0]                cpu_in_amount,
    input  logic                       cpu_in_new_max,
    input  logic                       exch_in_valid,
    output logic                       exch_in_ready,
    input  logic [4:0]                 exch_in_client_id,
    input  logic [15:0]                exch_in_amount,
    output logic                       cpu_go,
    output logic                       cpu_new_max,
    output logic [4:0]                 cpu_client_id,
    output logic [31:0]                cpu_amount,
    output logic                       exchange_go,
    output logic [4:0]                 exchange_client_id,
    output logic [15:0]                exchange_amount,
    output logic [$clog2(DEPTH):0]     cpu_level,
    output logic [$clog2(DEPTH):0]     exch_level
);

    localparam int PW    = $clog2(DEPTH);
    localparam int LW    = PW + 1;
    localparam int GW    = $clog2(GAP + 1);
    localparam int BW    = $clog2(EXCH_BURST + 1);
    localparam int CPU_W = 38;
    localparam int EX_W  = 21;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state;
    logic [GW-1:0]     gap_cnt;
    logic [BW-1:0]     burst_cnt;

    logic [CPU_W-1:0]  cpu_mem  [DEPTH];
    logic [EX_W-1:0]   exch_mem [DEPTH];
    logic [PW-1:0]     cpu_wr, cpu_rd, exch_wr, exch_rd;

    logic cpu_push, exch_push, cpu_pop, exch_pop;
    logic cpu_ne, exch_ne, sel_exch, sel_cpu;

    // Ready is held low while in reset so nothing is accepted before the first
    // released edge.
    assign cpu_in_ready  = HRESETn && (cpu_level  < LW'(DEPTH));
    assign exch_in_ready = HRESETn && (exch_level < LW'(DEPTH));
    assign cpu_push      = cpu_in_valid  && cpu_in_ready;
    assign exch_push     = exch_in_valid && exch_in_ready;

    assign cpu_ne   = (cpu_level  != '0);
    assign exch_ne  = (exch_level != '0);
    assign sel_exch = (state == IDLE) && exch_ne &&
                      !((burst_cnt == BW'(EXCH_BURST)) && cpu_ne);
    assign sel_cpu  = (state == IDLE) && cpu_ne && !sel_exch;
    assign cpu_pop  = sel_cpu;
    assign exch_pop = sel_exch;

    always_ff @(posedge clk) begin
        if (cpu_push)
            cpu_mem[cpu_wr] <= {cpu_in_new_max, cpu_in_client_id, cpu_in_amount};
        if (exch_push)
            exch_mem[exch_wr] <= {exch_in_client_id, exch_in_amount};
    end

    always_ff @(posedge clk) begin
        if (!HRESETn) begin
            cpu_wr     <= '0;
            cpu_rd     <= '0;
            exch_wr    <= '0;
            exch_rd    <= '0;
            cpu_level  <= '0;
            exch_level <= '0;
        end else begin
            if (cpu_push)  cpu_wr  <= cpu_wr + 1'b1;
            if (cpu_pop)   cpu_rd  <= cpu_rd + 1'b1;
            if (exch_push) exch_wr <= exch_wr + 1'b1;
            if (exch_pop)  exch_rd <= exch_rd + 1'b1;
            cpu_level  <= cpu_level  + LW'(cpu_push)  - LW'(cpu_pop);
            exch_level <= exch_level + LW'(exch_push) - LW'(exch_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!HRESETn) begin
            state              <= IDLE;
            gap_cnt            <= '0;
            burst_cnt          <= '0;
            cpu_go             <= 1'b0;
            exchange_go        <= 1'b0;
            cpu_new_max        <= 1'b0;
            cpu_client_id      <= '0;
            cpu_amount         <= '0;
            exchange_client_id <= '0;
            exchange_amount    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_exch) begin
                        exchange_go <= 1'b1;
                        {exchange_client_id, exchange_amount} <= exch_mem[exch_rd];
                        state <= ISSUE;
                        // Count only exchange issues that make a waiting CPU entry wait.
                        if (!cpu_ne)
                            burst_cnt <= '0;
                        else if (burst_cnt != BW'(EXCH_BURST))
                            burst_cnt <= burst_cnt + 1'b1;
                    end else if (sel_cpu) begin
                        cpu_go <= 1'b1;
                        {cpu_new_max, cpu_client_id, cpu_amount} <= cpu_mem[cpu_rd];
                        burst_cnt <= '0;
                        state     <= ISSUE;
                    end else begin
                        burst_cnt <= '0;
                    end
                end
                ISSUE: begin
                    cpu_go      <= 1'b0;
                    exchange_go <= 1'b0;
                    gap_cnt     <= GW'(GAP);
                    state       <= WAIT;
                end
                WAIT: begin
                    if (gap_cnt == GW'(1))
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_order_ingress_arbiter.sv
// Bench for order_ingress_arbiter: directed scenarios plus random traffic,
// all compared every cycle against a queue-based reference model.
module tb_order_ingress_arbiter;

    localparam int DEPTH      = 4;
    localparam int GAP        = 2;
    localparam int EXCH_BURST = 3;

    logic        clk = 1'b0;
    logic        HRESETn;
    logic        cpu_in_valid, cpu_in_ready, cpu_in_new_max;
    logic [4:0]  cpu_in_client_id;
    logic [31:0] cpu_in_amount;
    logic        exch_in_valid, exch_in_ready;
    logic [4:0]  exch_in_client_id;
    logic [15:0] exch_in_amount;
    logic        cpu_go, cpu_new_max, exchange_go;
    logic [4:0]  cpu_client_id, exchange_client_id;
    logic [31:0] cpu_amount;
    logic [15:0] exchange_amount;
    logic [2:0]  cpu_level, exch_level;

    always #5 clk = ~clk;

    order_ingress_arbiter #(.DEPTH(DEPTH), .GAP(GAP), .EXCH_BURST(EXCH_BURST)) dut (
        .clk(clk), .HRESETn(HRESETn),
        .cpu_in_valid(cpu_in_valid), .cpu_in_ready(cpu_in_ready),
        .cpu_in_client_id(cpu_in_client_id), .cpu_in_amount(cpu_in_amount),
        .cpu_in_new_max(cpu_in_new_max),
        .exch_in_valid(exch_in_valid), .exch_in_ready(exch_in_ready),
        .exch_in_client_id(exch_in_client_id), .exch_in_amount(exch_in_amount),
        .cpu_go(cpu_go), .cpu_new_max(cpu_new_max), .cpu_client_id(cpu_client_id),
        .cpu_amount(cpu_amount), .exchange_go(exchange_go),
        .exchange_client_id(exchange_client_id), .exchange_amount(exchange_amount),
        .cpu_level(cpu_level), .exch_level(exch_level)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Traffic sources: head entry is presented until accepted.
    logic [37:0] src_c[$];
    logic [20:0] src_e[$];

    // Reference model state.
    logic [37:0] m_cq[$];
    logic [20:0] m_eq[$];
    int          m_cool, m_burst;
    logic        m_cgo, m_ego, m_cnm;
    logic [4:0]  m_cid, m_eid;
    logic [31:0] m_camt;
    logic [15:0] m_eamt;

    // Observed issue history.
    logic [37:0] cpu_log[$];
    logic [20:0] exch_log[$];
    byte         ord[$];
    int          rise[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive();
        cpu_in_valid  = (src_c.size() > 0);
        exch_in_valid = (src_e.size() > 0);
        {cpu_in_new_max, cpu_in_client_id, cpu_in_amount} = cpu_in_valid ? src_c[0] : 38'd0;
        {exch_in_client_id, exch_in_amount} = exch_in_valid ? src_e[0] : 21'd0;
    endtask

    // Model of one rising edge: decision on pre-edge occupancy, then pushes.
    task automatic model_step();
        bit c_acc, e_acc, cne, ene;
        if (!HRESETn) begin
            m_cq.delete();
            m_eq.delete();
            m_cool = 0; m_burst = 0;
            m_cgo = 0; m_ego = 0; m_cnm = 0;
            m_cid = 0; m_eid = 0; m_camt = 0; m_eamt = 0;
        end else begin
            c_acc = cpu_in_valid  && (m_cq.size() < DEPTH);
            e_acc = exch_in_valid && (m_eq.size() < DEPTH);
            m_cgo = 0; m_ego = 0;
            if (m_cool == 0) begin
                cne = (m_cq.size() > 0);
                ene = (m_eq.size() > 0);
                if (ene && !(m_burst == EXCH_BURST && cne)) begin
                    m_ego = 1;
                    {m_eid, m_eamt} = m_eq.pop_front();
                    m_burst = !cne ? 0 : (m_burst + 1 > EXCH_BURST ? EXCH_BURST : m_burst + 1);
                    m_cool = GAP + 1;
                end else if (cne) begin
                    m_cgo = 1;
                    {m_cnm, m_cid, m_camt} = m_cq.pop_front();
                    m_burst = 0;
                    m_cool = GAP + 1;
                end else begin
                    m_burst = 0;
                end
            end else begin
                m_cool--;
            end
            if (c_acc) m_cq.push_back(src_c.pop_front());
            if (e_acc) m_eq.push_back(src_e.pop_front());
        end
    endtask

    task automatic tick();
        drive();
        model_step();
        @(negedge clk);
        cyc++;
        chk("cpu_go", cpu_go, m_cgo);
        chk("exchange_go", exchange_go, m_ego);
        chk("both_go", cpu_go & exchange_go, 0);
        chk("cpu_new_max", cpu_new_max, m_cnm);
        chk("cpu_client_id", cpu_client_id, m_cid);
        chk("cpu_amount", cpu_amount, m_camt);
        chk("exchange_client_id", exchange_client_id, m_eid);
        chk("exchange_amount", exchange_amount, m_eamt);
        chk("cpu_level", cpu_level, m_cq.size());
        chk("exch_level", exch_level, m_eq.size());
        chk("cpu_in_ready", cpu_in_ready, HRESETn && (m_cq.size() < DEPTH));
        chk("exch_in_ready", exch_in_ready, HRESETn && (m_eq.size() < DEPTH));
        if (cpu_go) begin
            cpu_log.push_back({cpu_new_max, cpu_client_id, cpu_amount});
            ord.push_back("C");
            rise.push_back(cyc);
        end
        if (exchange_go) begin
            exch_log.push_back({exchange_client_id, exchange_amount});
            ord.push_back("E");
            rise.push_back(cyc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_logs();
        cpu_log.delete(); exch_log.delete(); ord.delete(); rise.delete();
    endtask

    initial begin
        string exp_ord;
        bit    stall_seen;
        int    go_cnt;
        logic [63:0] rv;

        HRESETn = 1'b0;
        drive();
        idle(3);
        chk("rst_cpu_level", cpu_level, 0);
        chk("rst_exch_ready", exch_in_ready, 0);
        HRESETn = 1'b1;

        // Single CPU order
        clear_logs();
        src_c.push_back({1'b0, 5'd5, 32'd100});
        tick();
        chk("t1_level", cpu_level, 1);
        chk("t1_go_early", cpu_go, 0);
        tick();
        chk("t1_go", cpu_go, 1);
        chk("t1_id", cpu_client_id, 5);
        chk("t1_amount", cpu_amount, 100);
        tick();
        chk("t1_go_pulse", cpu_go, 0);
        idle(8);
        chk("t1_no_exch", exch_log.size(), 0);

        // Five CPU entries behind a busy FSM
        clear_logs();
        stall_seen = 0;
        src_e.push_back({5'd1, 16'd7});
        for (int i = 0; i < 5; i++) src_c.push_back({1'b0, 5'(10 + i), 32'(1000 + i)});
        for (int i = 0; i < 35; i++) begin
            tick();
            if (!cpu_in_ready && cpu_level == 3'd4 && src_c.size() > 0) stall_seen = 1;
        end
        chk("t2_stall", stall_seen, 1);
        chk("t2_count", cpu_log.size(), 5);
        for (int i = 0; i < cpu_log.size() && i < 5; i++)
            chk("t2_order", cpu_log[i], {1'b0, 5'(10 + i), 32'(1000 + i)});

        // Exchange burst limit
        idle(5);
        clear_logs();
        for (int i = 0; i < 2; i++) src_c.push_back({1'b0, 5'd2, 32'(200 + i)});
        for (int i = 0; i < 6; i++) src_e.push_back({5'd3, 16'(300 + i)});
        idle(45);
        exp_ord = "EEECEEEC";
        chk("t3_count", ord.size(), 8);
        for (int i = 0; i < ord.size() && i < 8; i++) chk("t3_order", ord[i], exp_ord[i]);
        for (int i = 1; i < rise.size(); i++) chk("t3_spacing", rise[i] - rise[i-1], GAP + 2);

        // Max update followed by an order
        idle(5);
        clear_logs();
        src_c.push_back({1'b1, 5'd3, 32'h0001_0000});
        src_c.push_back({1'b0, 5'd3, 32'd50});
        idle(12);
        chk("t4_count", cpu_log.size(), 2);
        if (cpu_log.size() >= 2) begin
            chk("t4_nm0", cpu_log[0][37], 1);
            chk("t4_amt0", cpu_log[0][31:0], 32'h0001_0000);
            chk("t4_nm1", cpu_log[1][37], 0);
            chk("t4_amt1", cpu_log[1][31:0], 50);
        end

        // Reset during the gap with entries buffered
        idle(5);
        for (int i = 0; i < 4; i++) src_c.push_back({1'b0, 5'd9, 32'(900 + i)});
        idle(4);
        chk("t5_level_pre", cpu_level, 3);
        HRESETn = 1'b0;
        tick();
        chk("t5_cpu_level", cpu_level, 0);
        chk("t5_cpu_go", cpu_go, 0);
        chk("t5_cpu_amount", cpu_amount, 0);
        chk("t5_cpu_id", cpu_client_id, 0);
        chk("t5_ready", cpu_in_ready, 0);
        HRESETn = 1'b1;
        go_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (cpu_go || exchange_go) go_cnt++;
        end
        chk("t5_no_stale", go_cnt, 0);

        // Exchange push/pop at level 2, pointer wrap over 10 entries
        clear_logs();
        src_e.push_back({5'd20, 16'd0});
        idle(3);
        for (int i = 1; i < 10; i++) src_e.push_back({5'd20, 16'(i)});
        idle(2);
        chk("t6_level2", exch_level, 2);
        tick();
        chk("t6_pop", exchange_go, 1);
        chk("t6_level_hold", exch_level, 2);
        idle(45);
        chk("t6_count", exch_log.size(), 10);
        for (int i = 0; i < exch_log.size() && i < 10; i++)
            chk("t6_order", exch_log[i], {5'd20, 16'(i)});

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0 && src_c.size() < 3) begin
                rv = {$urandom(), $urandom()};
                src_c.push_back(rv[37:0]);
            end
            if ($urandom_range(0, 2) == 0 && src_e.size() < 3) begin
                rv = {$urandom(), $urandom()};
                src_e.push_back(rv[20:0]);
            end
            HRESETn = ($urandom_range(0, 399) != 0);
            tick();
        end
        HRESETn = 1'b1;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
